// File: rtl/ntt_controller.sv
// Issue sequencer for a 16-point forward NTT (Cooley-Tukey, bit-reversed twiddles).
// Walks 4 stages x 8 butterflies, drains the butterfly pipeline between stages, pulses done.
module ntt_controller #(
  parameter int unsigned BF_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       bf_ready,
  output logic       bf_valid,
  output logic [3:0] addr_a,
  output logic [3:0] addr_b,
  output logic [3:0] psi_addr,
  output logic [1:0] stage,
  output logic       busy,
  output logic       done
);

  localparam int unsigned AddrW  = 4;
  localparam int unsigned KW     = 3;
  localparam int unsigned StageW = 2;
  localparam int unsigned CntW   = 4;
  localparam logic [CntW-1:0] DrainLast = CntW'(BF_LATENCY == 0 ? 0 : BF_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [AddrW-1:0] a;
    logic [AddrW-1:0] b;
    logic [AddrW-1:0] p;
  } addr_t;

  state_e            state_q;
  logic [KW-1:0]     k_q;
  logic [StageW-1:0] stage_q;
  logic [CntW-1:0]   drain_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  addr_t             addr_q;

  // t = 8>>s is a power of two, so div/mod reduce to shift/mask
  function automatic addr_t gen_addr(input logic [StageW-1:0] s, input logic [KW-1:0] k);
    logic [AddrW-1:0] kk, t, i, j;
    addr_t r;
    kk  = {1'b0, k};
    t   = 4'd8 >> s;
    i   = kk >> (2'd3 - s);
    j   = (i << (3'd4 - {1'b0, s})) | (kk & (t - 4'd1));
    r.a = j;
    r.b = j + t;
    r.p = (4'd1 << s) + i;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      drain_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            k_q     <= '0;
            stage_q <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            addr_q  <= gen_addr(2'd0, 3'd0);
          end
        end
        RUN: begin
          if (bf_ready) begin
            if (k_q != 3'd7) begin
              k_q    <= k_q + 3'd1;
              addr_q <= gen_addr(stage_q, k_q + 3'd1);
            end else if (BF_LATENCY != 0) begin
              state_q <= DRAIN;
              valid_q <= 1'b0;
              drain_q <= DrainLast;
            end else if (stage_q != 2'd3) begin
              stage_q <= stage_q + 2'd1;
              k_q     <= '0;
              addr_q  <= gen_addr(stage_q + 2'd1, 3'd0);
            end else begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_q != '0) begin
            drain_q <= drain_q - 4'd1;
          end else if (stage_q != 2'd3) begin
            state_q <= RUN;
            stage_q <= stage_q + 2'd1;
            k_q     <= '0;
            valid_q <= 1'b1;
            addr_q  <= gen_addr(stage_q + 2'd1, 3'd0);
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bf_valid = valid_q;
  assign addr_a   = addr_q.a;
  assign addr_b   = addr_q.b;
  assign psi_addr = addr_q.p;
  assign stage    = stage_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ntt_controller.sv
// Scoreboard bench for ntt_controller: one instance with BF_LATENCY=4, one with BF_LATENCY=0.
module tb_ntt_controller;

  typedef struct packed {
    logic [1:0] s;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] p;
  } issue_t;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, ready_a, ready_b;
  logic va, vb, busya, busyb, donea, doneb;
  logic [3:0] aa, ba, pa, ab, bb, pb;
  logic [1:0] sa, sb;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  issue_t qa[$];
  issue_t qb[$];
  issue_t act_a[32];
  int acc_a = 0, acc_b = 0, done_a_cnt = 0;
  bit rnd_a = 1'b0;
  bit prev_stall = 1'b0;
  logic [13:0] prev_vec;
  logic prev_valid;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_controller #(.BF_LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bf_ready(ready_a), .bf_valid(va),
    .addr_a(aa), .addr_b(ba), .psi_addr(pa), .stage(sa), .busy(busya), .done(donea)
  );

  ntt_controller #(.BF_LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bf_ready(ready_b), .bf_valid(vb),
    .addr_a(ab), .addr_b(bb), .psi_addr(pb), .stage(sb), .busy(busyb), .done(doneb)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference order from the textbook Cooley-Tukey forward NTT loop nest
  function automatic issue_t exp_issue(input int idx);
    issue_t r;
    int t, m, n;
    r = '0; t = 16; m = 1; n = 0;
    for (int st = 0; st < 4; st++) begin
      t = t / 2;
      for (int i = 0; i < m; i++) begin
        for (int j = 2 * i * t; j < 2 * i * t + t; j++) begin
          if (n == idx) begin
            r.s = 2'(st); r.a = 4'(j); r.b = 4'(j + t); r.p = 4'(m + i);
          end
          n++;
        end
      end
      m = m * 2;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    ready_a = rnd_a ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor A: pops expected issue on every accepted handshake, checks hold during stalls
  always @(negedge clk) begin
    issue_t e;
    if (!rst) begin
      if (prev_stall) begin
        check("a_hold_valid", int'(va), int'(prev_valid));
        check("a_hold_issue", int'({sa, aa, ba, pa}), int'(prev_vec));
      end
      if (va && ready_a) begin
        if (acc_a < 32) act_a[acc_a] = {sa, aa, ba, pa};
        acc_a++;
        check("a_psi_nonzero", int'(pa != 4'd0), 1);
        check("a_span", int'(ba - aa), int'(4'd8 >> sa));
        if (qa.size() == 0) check("a_unexpected_issue", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_issue", int'({sa, aa, ba, pa}), int'(e));
        end
      end
      if (donea) done_a_cnt++;
      prev_stall = va && !ready_a;
      prev_valid = va;
      prev_vec   = {sa, aa, ba, pa};
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(negedge clk) begin
    issue_t e;
    if (!rst && vb && ready_b) begin
      acc_b++;
      if (qb.size() == 0) check("b_unexpected_issue", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_issue", int'({sb, ab, bb, pb}), int'(e));
      end
    end
  end

  task automatic run_a(input bit rnd, input int exp_lat, input bit inject);
    int c0;
    bit got;
    for (int i = 0; i < 32; i++) qa.push_back(exp_issue(i));
    acc_a = 0; done_a_cnt = 0; rnd_a = rnd; got = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("a_valid_after_start", int'(va), 1);
    c0 = cyc;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      start_a = inject && (n == 2 || n == 9);
      if (donea) begin
        got = 1'b1;
        check("a_busy_with_done", int'(busya), 1);
        if (exp_lat >= 0) check("a_done_latency", cyc - c0, exp_lat);
      end
    end
    start_a = 1'b0;
    if (!got) check("a_done_timeout", 0, 1);
    repeat (inject ? 60 : 4) @(negedge clk);
    check("a_done_pulses", done_a_cnt, 1);
    check("a_idle_after", int'(busya), 0);
    check("a_accepted", acc_a, 32);
    check("a_queue_empty", qa.size(), 0);
    rnd_a = 1'b0;
  endtask

  task automatic spot_checks();
    int seen[16];
    int bad;
    check("s0k0", int'(act_a[0]),  int'(14'({2'd0, 4'd0,  4'd8,  4'd1})));
    check("s0k7", int'(act_a[7]),  int'(14'({2'd0, 4'd7,  4'd15, 4'd1})));
    check("s1k4", int'(act_a[12]), int'(14'({2'd1, 4'd8,  4'd12, 4'd3})));
    check("s3k5", int'(act_a[29]), int'(14'({2'd3, 4'd10, 4'd11, 4'd13})));
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 16; i++) seen[i] = 0;
      for (int k = 0; k < 8; k++) begin
        seen[act_a[s * 8 + k].a]++;
        seen[act_a[s * 8 + k].b]++;
      end
      bad = 0;
      for (int i = 0; i < 16; i++) if (seen[i] != 1) bad++;
      check("stage_addr_cover", bad, 0);
    end
  endtask

  task automatic run_b();
    int c0, gaps;
    bit got;
    for (int i = 0; i < 32; i++) qb.push_back(exp_issue(i));
    acc_b = 0; gaps = 0; got = 1'b0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    check("b_valid_after_start", int'(vb), 1);
    c0 = cyc;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (doneb) begin
        got = 1'b1;
        check("b_done_latency", cyc - c0, 32);
      end else if (!vb) gaps++;
    end
    if (!got) check("b_done_timeout", 0, 1);
    check("b_valid_gaps", gaps, 0);
    check("b_accepted", acc_b, 32);
    check("b_queue_empty", qb.size(), 0);
    repeat (3) @(negedge clk);
    check("b_idle_after", int'(busyb), 0);
  endtask

  task automatic reset_test();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 32; i++) qa.push_back(exp_issue(i));
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      if (va && sa == 2'd2 && aa == 4'd5 && pa == 4'd5) hit = 1'b1;
    end
    check("a_reached_s2k3", int'(hit), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", int'(va), 0);
    check("rst_addr_a", int'(aa), 0);
    check("rst_addr_b", int'(ba), 0);
    check("rst_psi", int'(pa), 0);
    check("rst_stage", int'(sa), 0);
    check("rst_busy", int'(busya), 0);
    check("rst_done", int'(donea), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    qa.delete();
    repeat (3) @(negedge clk);
    check("post_rst_idle_busy", int'(busya), 0);
    check("post_rst_idle_valid", int'(va), 0);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(negedge clk);
    check("init_valid", int'(va), 0);
    check("init_addrs", int'({aa, ba, pa, sa}), 0);
    check("init_busy_done", int'({busya, donea}), 0);
    check("init_b_outs", int'({vb, ab, bb, pb, sb, busyb, doneb}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_busy", int'(busya), 0);

    run_b();
    run_a(1'b0, 48, 1'b0);
    spot_checks();
    run_a(1'b1, -1, 1'b0);
    spot_checks();
    run_a(1'b0, 48, 1'b1);
    reset_test();
    run_a(1'b0, 48, 1'b0);
    spot_checks();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_controller.md
NTT_CONTROLLER -- requirements
Module: ntt_controller

Interface
REQ-001 Parameter BF_LATENCY, default 4, range 0..15: butterfly pipeline depth in cycles to drain between stages.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a 16-point forward NTT; ignored unless IDLE.
REQ-005 bf_ready  input  1  butterfly unit accepts the current issue.
REQ-006 bf_valid  output  1  an issue (addr_a, addr_b, psi_addr) is presented.
REQ-007 addr_a  output  4  coefficient memory address of the upper butterfly operand.
REQ-008 addr_b  output  4  coefficient memory address of the lower butterfly operand.
REQ-009 psi_addr  output  4  address to the 16-entry twiddle ROM (bit-reversed powers of psi mod 257).
REQ-010 stage  output  2  current stage index s, 0..3.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on transform completion.

Function
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE -> RUN on start=1; stage and butterfly counter k cleared to 0.
REQ-016 In RUN, the block SHALL present bf_valid=1 with addresses for (stage s, k); an issue completes when bf_valid and bf_ready are both 1 at a rising edge.
REQ-017 While bf_ready=0, bf_valid, addr_a, addr_b, psi_addr and stage SHALL hold stable.
REQ-018 Address generation for stage s, k = 0..7: t = 8>>s, m = 1<<s, i = k div t, j = 2*i*t + (k mod t); addr_a = j, addr_b = j + t, psi_addr = m + i.
REQ-019 psi_addr SHALL never be 0; the full run covers indices 1..15.
REQ-020 After the issue completing k=7, the FSM SHALL go to DRAIN with bf_valid=0 for exactly BF_LATENCY cycles; if BF_LATENCY=0, DRAIN is skipped.
REQ-021 DRAIN exit: if s<3, increment s, clear k, go to RUN; if s=3, go to DONE.
REQ-022 DONE SHALL last one cycle with done=1, busy=1, then return to IDLE.
REQ-023 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 With bf_ready held 1, the first bf_valid SHALL occur the cycle after start, and done SHALL assert exactly 4*(8+BF_LATENCY) cycles after the first bf_valid cycle.
REQ-025 Exactly 32 issues SHALL complete per transform, 8 per stage, in increasing k order.
REQ-026 bf_ready is don't-care outside RUN.

Reset
REQ-027 Reset SHALL force state IDLE, k=0, and bf_valid=0, addr_a=0, addr_b=0, psi_addr=0, stage=0, busy=0, done=0, asynchronously, including mid-transform.
REQ-028 After reset deasserts, the block SHALL require a new start; no partial transform resumes.

Verification
REQ-029 Ready held 1, BF_LATENCY=4, start pulse: expect 32 issues; stage 0 k=0 -> (0,8,1); k=7 -> (7,15,1); stage 1 k=4 -> (8,12,3); stage 3 k=5 -> (10,11,13); done 48 cycles after first bf_valid.
REQ-030 bf_ready toggled pseudo-randomly: issue sequence identical to REQ-029, outputs stable during stalls, and 32 accepted issues total.
REQ-031 BF_LATENCY=0: no bf_valid gaps between stages; done 32 cycles after first bf_valid.
REQ-032 start pulsed during RUN and during DRAIN: ignored, single done pulse, returns to IDLE.
REQ-033 rst asserted at stage 2, k=3: all outputs 0 immediately; after release, start reproduces the REQ-029 sequence from stage 0, k=0.
REQ-034 Every issue: psi_addr in 1..15, addr_b - addr_a = 8>>stage; each address 0..15 appears exactly once as addr_a or addr_b per stage.
